// File: rtl/pc_gen_if.sv
// Fetch-side bus between the PC generator and instruction memory.
// The generator presents PC/FetchValid, imem answers with FetchReady.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlusInc;
    logic             FetchValid;
    logic             FetchReady;

    modport master (
        output PC,
        output PCPlusInc,
        output FetchValid,
        input  FetchReady
    );

    modport slave (
        input  PC,
        input  PCPlusInc,
        input  FetchValid,
        output FetchReady
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential, branch, jalr and trap
// next-PC modes with stall, halt, misalign detection and fetch counting.
module pc_gen #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           PCsrc,
    input  logic [WIDTH-1:0]     ImmOP,
    input  logic [WIDTH-1:0]     RS1,
    input  logic [WIDTH-1:0]     TrapVec,
    input  logic                 Stall,
    input  logic                 Halt,
    pc_gen_if.master             fetch,
    output logic                 MisalignErr,
    output logic [WIDTH-1:0]     MisalignAddr,
    output logic [CNT_WIDTH-1:0] FetchCount
);
    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    localparam logic [WIDTH-1:0] LSB_CLR    = ~WIDTH'(1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic                 fv_q, fv_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     addr_q, addr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             is_trap;
    logic             is_redir;
    logic             accept;

    always_comb begin
        is_trap  = (PCsrc == 2'b11);
        is_redir = (PCsrc == 2'b01) || (PCsrc == 2'b10);
        if (PCsrc == 2'b01) begin
            target = pc_q + ImmOP;
        end else begin
            target = (RS1 + ImmOP) & LSB_CLR;
        end
        misaligned = |(target & ALIGN_MASK);
        accept = (state_q == RUN) && fv_q
               && fetch.FetchReady && !Stall;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (accept && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                unique case (1'b1)
                    is_trap: pc_d = TrapVec;
                    is_redir: begin
                        // Misaligned redirects vector to the trap handler.
                        if (misaligned) begin
                            pc_d   = TrapVec;
                            err_d  = 1'b1;
                            addr_d = target;
                        end else begin
                            pc_d = target;
                        end
                    end
                    default: begin
                        if (Halt) begin
                            state_d = HALT;
                        end else if (!Stall && fetch.FetchReady) begin
                            pc_d = pc_q + INC_W;
                        end
                    end
                endcase
            end
            HALT: begin
                if (is_trap) begin
                    pc_d    = TrapVec;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        fv_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fetch.PC         = pc_q;
    assign fetch.PCPlusInc  = pc_q + INC_W;
    assign fetch.FetchValid = fv_q;
    assign MisalignErr      = err_q;
    assign MisalignAddr     = addr_q;
    assign FetchCount       = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model of the PC rules.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic [31:0] ImmOP = '0;
    logic [31:0] RS1 = '0;
    logic [31:0] TrapVec = '0;
    logic        Stall = 1'b0;
    logic        Halt = 1'b0;
    logic        FetchReady = 1'b0;
    logic        MisalignErr;
    logic [31:0] MisalignAddr;
    logic [3:0]  FetchCount;

    pc_gen_if #(.WIDTH(32)) bus ();
    assign bus.FetchReady = FetchReady;

    pc_gen #(
        .WIDTH(32),
        .RESET_VECTOR(RV),
        .INC(4),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PCsrc(PCsrc),
        .ImmOP(ImmOP),
        .RS1(RS1),
        .TrapVec(TrapVec),
        .Stall(Stall),
        .Halt(Halt),
        .fetch(bus.master),
        .MisalignErr(MisalignErr),
        .MisalignAddr(MisalignAddr),
        .FetchCount(FetchCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode = 0;
    logic [31:0] m_pc = RV;
    logic        m_err = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;

    task automatic step();
        int          n_mode = m_mode;
        logic [31:0] n_pc = m_pc;
        logic        n_err = 1'b0;
        logic [31:0] n_addr = m_addr;
        int          n_cnt = m_cnt;
        logic [31:0] tgt;
        if (rst) begin
            n_mode = 0; n_pc = RV; n_addr = '0; n_cnt = 0;
        end else if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 2) begin
            if (PCsrc == 2'b11) begin
                n_mode = 1; n_pc = TrapVec;
            end
        end else begin
            if (FetchReady && !Stall && m_cnt < 15) n_cnt = m_cnt + 1;
            if (PCsrc == 2'b11) begin
                n_pc = TrapVec;
            end else if (PCsrc != 2'b00) begin
                if (PCsrc == 2'b01) tgt = m_pc + ImmOP;
                else tgt = (RS1 + ImmOP) & 32'hFFFF_FFFE;
                if (tgt % 4 != 0) begin
                    n_pc = TrapVec; n_err = 1'b1; n_addr = tgt;
                end else begin
                    n_pc = tgt;
                end
            end else if (Halt) begin
                n_mode = 2;
            end else if (!Stall && FetchReady) begin
                n_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_err = n_err;
        m_addr = n_addr; m_cnt = n_cnt;
    endtask

    task automatic idle();
        rst = 1'b0; PCsrc = 2'b00; Stall = 1'b0;
        Halt = 1'b0; FetchReady = 1'b1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0;
        checks += 5;
        if (bus.PC !== 32'h100) begin errors++;
            $display("FAIL reset_pc got %h exp 100", bus.PC); end
        if (bus.FetchValid !== 1'b0) begin errors++;
            $display("FAIL reset_fv got %b exp 0", bus.FetchValid); end
        if (MisalignErr !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b exp 0", MisalignErr); end
        if (MisalignAddr !== 32'h0) begin errors++;
            $display("FAIL reset_addr got %h exp 0", MisalignAddr); end
        if (FetchCount !== 4'd0) begin errors++;
            $display("FAIL reset_cnt got %0d exp 0", FetchCount); end
        step();
        checks += 2;
        if (bus.FetchValid !== 1'b1) begin errors++;
            $display("FAIL boot_fv got %b exp 1", bus.FetchValid); end
        if (bus.PC !== 32'h100) begin errors++;
            $display("FAIL boot_pc got %h exp 100", bus.PC); end
        step();
        checks += 2;
        if (bus.PC !== 32'h104) begin errors++;
            $display("FAIL seq1_pc got %h exp 104", bus.PC); end
        if (bus.PCPlusInc !== 32'h108) begin errors++;
            $display("FAIL seq1_link got %h exp 108", bus.PCPlusInc); end
        step();
        checks++;
        if (bus.PC !== 32'h108) begin errors++;
            $display("FAIL seq2_pc got %h exp 108", bus.PC); end
    endtask

    task automatic test_branch_stall();
        logic [3:0] c0;
        idle(); PCsrc = 2'b11; TrapVec = 32'h20; step();
        idle(); c0 = FetchCount;
        PCsrc = 2'b01; ImmOP = -32'sd8; Stall = 1'b1; step();
        checks += 3;
        if (bus.PC !== 32'h18) begin errors++;
            $display("FAIL branch_pc got %h exp 18", bus.PC); end
        if (FetchCount !== c0) begin errors++;
            $display("FAIL branch_cnt got %0d exp %0d", FetchCount, c0); end
        if (MisalignErr !== 1'b0) begin errors++;
            $display("FAIL branch_err got %b exp 0", MisalignErr); end
    endtask

    task automatic test_misalign();
        idle(); PCsrc = 2'b10; RS1 = 32'h1001; ImmOP = 32'd2;
        TrapVec = 32'h80; step();
        checks += 3;
        if (bus.PC !== 32'h80) begin errors++;
            $display("FAIL mis_pc got %h exp 80", bus.PC); end
        if (MisalignErr !== 1'b1) begin errors++;
            $display("FAIL mis_err got %b exp 1", MisalignErr); end
        if (MisalignAddr !== 32'h1002) begin errors++;
            $display("FAIL mis_addr got %h exp 1002", MisalignAddr); end
        idle(); Stall = 1'b1; step();
        checks += 2;
        if (MisalignErr !== 1'b0) begin errors++;
            $display("FAIL mis_pulse got %b exp 0", MisalignErr); end
        if (MisalignAddr !== 32'h1002) begin errors++;
            $display("FAIL mis_hold got %h exp 1002", MisalignAddr); end
        idle(); PCsrc = 2'b10; RS1 = 32'h2001; ImmOP = 32'd3; step();
        checks++;
        if (bus.PC !== 32'h2004) begin errors++;
            $display("FAIL jalr_pc got %h exp 2004", bus.PC); end
    endtask

    task automatic test_wrap();
        idle(); PCsrc = 2'b11; TrapVec = 32'hFFFF_FFFC; step();
        idle(); step();
        checks++;
        if (bus.PC !== 32'h0) begin errors++;
            $display("FAIL wrap_pc got %h exp 0", bus.PC); end
        for (int i = 0; i < 3; i++) begin
            idle(); FetchReady = 1'b0; step();
            checks++;
            if (bus.PC !== 32'h0) begin errors++;
                $display("FAIL ready_hold got %h exp 0", bus.PC); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] p0;
        idle(); p0 = bus.PC; Halt = 1'b1; step();
        checks += 2;
        if (bus.FetchValid !== 1'b0) begin errors++;
            $display("FAIL halt_fv got %b exp 0", bus.FetchValid); end
        if (bus.PC !== p0) begin errors++;
            $display("FAIL halt_pc got %h exp %h", bus.PC, p0); end
        idle(); PCsrc = 2'b01; ImmOP = 32'h40; step();
        checks += 2;
        if (bus.PC !== p0) begin errors++;
            $display("FAIL halt_br got %h exp %h", bus.PC, p0); end
        if (bus.FetchValid !== 1'b0) begin errors++;
            $display("FAIL halt_br_fv got %b exp 0", bus.FetchValid); end
        idle(); PCsrc = 2'b11; TrapVec = 32'h200; step();
        checks += 2;
        if (bus.PC !== 32'h200) begin errors++;
            $display("FAIL halt_exit got %h exp 200", bus.PC); end
        if (bus.FetchValid !== 1'b1) begin errors++;
            $display("FAIL halt_exit_fv got %b exp 1", bus.FetchValid); end
        idle(); Halt = 1'b1; PCsrc = 2'b01; ImmOP = 32'h10; step();
        checks += 2;
        if (bus.PC !== 32'h210) begin errors++;
            $display("FAIL halt_redir got %h exp 210", bus.PC); end
        if (bus.FetchValid !== 1'b1) begin errors++;
            $display("FAIL halt_redir_fv got %b exp 1", bus.FetchValid); end
    endtask

    task automatic test_saturate();
        idle(); rst = 1'b1; step(); idle(); step();
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (FetchCount !== 4'hF) begin errors++;
            $display("FAIL sat_cnt got %0d exp 15", FetchCount); end
        idle(); rst = 1'b1; Halt = 1'b1; PCsrc = 2'b11; step();
        checks += 4;
        if (bus.PC !== RV) begin errors++;
            $display("FAIL mid_rst_pc got %h exp %h", bus.PC, RV); end
        if (FetchCount !== 4'd0) begin errors++;
            $display("FAIL mid_rst_cnt got %0d exp 0", FetchCount); end
        if (bus.FetchValid !== 1'b0) begin errors++;
            $display("FAIL mid_rst_fv got %b exp 0", bus.FetchValid); end
        if (MisalignAddr !== 32'h0) begin errors++;
            $display("FAIL mid_rst_addr got %h exp 0", MisalignAddr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            PCsrc = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            ImmOP = ($urandom_range(0, 3) == 0) ? $urandom
                  : ($urandom_range(0, 255) << 2);
            RS1 = ($urandom_range(0, 1) == 0) ? $urandom
                : ($urandom & 32'hFFFF_FFFC);
            TrapVec = $urandom & 32'hFFFF_FFFC;
            Stall = ($urandom_range(0, 4) == 0);
            Halt = ($urandom_range(0, 20) == 0);
            FetchReady = ($urandom_range(0, 3) != 0);
            step();
            checks += 6;
            if (bus.PC !== m_pc) begin errors++;
                $display("FAIL rnd_pc got %h exp %h", bus.PC, m_pc); end
            if (bus.PCPlusInc !== m_pc + 32'd4) begin errors++;
                $display("FAIL rnd_link got %h exp %h",
                         bus.PCPlusInc, m_pc + 32'd4); end
            if (bus.FetchValid !== (m_mode == 1)) begin errors++;
                $display("FAIL rnd_fv got %b exp %b",
                         bus.FetchValid, m_mode == 1); end
            if (MisalignErr !== m_err) begin errors++;
                $display("FAIL rnd_err got %b exp %b", MisalignErr, m_err); end
            if (MisalignAddr !== m_addr) begin errors++;
                $display("FAIL rnd_addr got %h exp %h", MisalignAddr, m_addr); end
            if (FetchCount !== 4'(m_cnt)) begin errors++;
                $display("FAIL rnd_cnt got %0d exp %0d", FetchCount, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_branch_stall();
        test_misalign();
        test_wrap();
        test_halt();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
